// File: rtl/packet_tx_scheduler.sv
// packet_tx_scheduler: frames packets from the packet buffer into a serial
// bit stream for the BPSK modulator: preamble, sync word, payload, gap.
// One extra packet can wait in a holding register while a frame is in
// flight. Any packet beyond that is dropped and flagged.
// Optional feature macro: PACKET_TX_CRC8_EN adds a CRC-8 field (poly 0x07)
// between the payload and the gap.
module packet_tx_scheduler #(
    parameter int          PACKET_BYTES  = 8,
    parameter int          PREAMBLE_BITS = 16,
    parameter logic [15:0] SYNC_WORD     = 16'hD391,
    parameter int          GAP_BITS      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PACKET_BYTES*8-1:0] packet_in,
    input  logic                      packet_valid,
    input  logic                      bit_tick,
    output logic                      tx_bit,
    output logic                      tx_valid,
    output logic                      tx_busy,
    output logic                      hold_full,
    output logic                      dropped
);

    localparam int PAYLOAD_BITS = PACKET_BYTES * 8;
    localparam int SYNC_BITS    = 16;
    localparam int SEG_A        = (PREAMBLE_BITS > SYNC_BITS) ? PREAMBLE_BITS : SYNC_BITS;
    localparam int SEG_B        = (PAYLOAD_BITS > GAP_BITS) ? PAYLOAD_BITS : GAP_BITS;
    localparam int MAX_SEG      = (SEG_A > SEG_B) ? SEG_A : SEG_B;
    localparam int CNT_W        = $clog2(MAX_SEG) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SYNC,
        S_PAYLOAD,
`ifdef PACKET_TX_CRC8_EN
        S_CRC,
`endif
        S_GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [PAYLOAD_BITS-1:0] hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    tx_bit_q, tx_bit_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    dropped_q, dropped_d;
    logic                    gap_exit;
`ifdef PACKET_TX_CRC8_EN
    logic [7:0]              crc_q, crc_d;

    // One CRC-8 step (x^8+x^2+x+1) for a single payload bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    // Rearrange a packet so that transmit order (byte 0 first, MSB first
    // within each byte) runs from the top bit of the shift register down.
    function automatic logic [PAYLOAD_BITS-1:0] tx_order(input logic [PAYLOAD_BITS-1:0] pkt);
        logic [PAYLOAD_BITS-1:0] r;
        r = '0;
        for (int b = 0; b < PACKET_BYTES; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[PAYLOAD_BITS-1-(b*8+i)] = pkt[b*8+7-i];
            end
        end
        return r;
    endfunction

    // Next-state, bit generation and holding-register arbitration.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_bit_d    = tx_bit_q;
        tx_valid_d  = tx_valid_q;
        dropped_d   = 1'b0;
`ifdef PACKET_TX_CRC8_EN
        crc_d       = crc_q;
`endif
        gap_exit    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A tick arriving with the packet is not consumed here.
                if (packet_valid) begin
                    shift_d   = tx_order(packet_in);
                    bit_cnt_d = '0;
                    state_d   = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (bit_tick) begin
                    tx_bit_d   = ~bit_cnt_q[0];
                    tx_valid_d = 1'b1;
                    if (bit_cnt_q == CNT_W'(PREAMBLE_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_SYNC;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_SYNC: begin
                if (bit_tick) begin
                    tx_bit_d   = SYNC_WORD[4'd15 - bit_cnt_q[3:0]];
                    tx_valid_d = 1'b1;
                    if (bit_cnt_q == CNT_W'(SYNC_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_PAYLOAD;
`ifdef PACKET_TX_CRC8_EN
                        crc_d     = 8'h00;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PAYLOAD: begin
                if (bit_tick) begin
                    tx_bit_d   = shift_q[PAYLOAD_BITS-1];
                    tx_valid_d = 1'b1;
                    shift_d    = shift_q << 1;
`ifdef PACKET_TX_CRC8_EN
                    crc_d      = crc8_step(crc_q, shift_q[PAYLOAD_BITS-1]);
`endif
                    if (bit_cnt_q == CNT_W'(PAYLOAD_BITS - 1)) begin
                        bit_cnt_d = '0;
`ifdef PACKET_TX_CRC8_EN
                        state_d   = S_CRC;
`else
                        state_d   = S_GAP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef PACKET_TX_CRC8_EN
            S_CRC: begin
                if (bit_tick) begin
                    tx_bit_d   = crc_q[3'd7 - bit_cnt_q[2:0]];
                    tx_valid_d = 1'b1;
                    if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            S_GAP: begin
                if (bit_tick) begin
                    tx_bit_d   = 1'b0;
                    tx_valid_d = 1'b0;
                    if (bit_cnt_q == CNT_W'(GAP_BITS - 1)) begin
                        gap_exit = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Gap exit chains straight into the next frame when one is waiting,
        // so back-to-back frames never pass through IDLE.
        if (gap_exit) begin
            bit_cnt_d = '0;
            if (hold_full_q) begin
                shift_d = tx_order(hold_q);
                state_d = S_PREAMBLE;
                if (packet_valid) begin
                    hold_d = packet_in;
                end else begin
                    hold_full_d = 1'b0;
                end
            end else if (packet_valid) begin
                shift_d = tx_order(packet_in);
                state_d = S_PREAMBLE;
            end else begin
                state_d = S_IDLE;
            end
        end else if (state_q != S_IDLE && packet_valid) begin
            if (!hold_full_q) begin
                hold_d      = packet_in;
                hold_full_d = 1'b1;
            end else begin
                dropped_d = 1'b1;
            end
        end
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_bit_q    <= 1'b0;
            tx_valid_q  <= 1'b0;
            dropped_q   <= 1'b0;
`ifdef PACKET_TX_CRC8_EN
            crc_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_bit_q    <= tx_bit_d;
            tx_valid_q  <= tx_valid_d;
            dropped_q   <= dropped_d;
`ifdef PACKET_TX_CRC8_EN
            crc_q       <= crc_d;
`endif
        end
    end

    assign tx_bit    = tx_bit_q;
    assign tx_valid  = tx_valid_q;
    assign tx_busy   = (state_q != S_IDLE);
    assign hold_full = hold_full_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_packet_tx_scheduler.sv
// Bench for packet_tx_scheduler: a frame-level symbol-queue model plus
// directed scenarios with literal expectations and a randomized soak.
module tb_packet_tx_scheduler;

    localparam int          PB     = 8;
    localparam int          NBITS  = PB * 8;
    localparam int          PREB   = 16;
    localparam int          GAPB   = 8;
    localparam logic [15:0] SW     = 16'hD391;
`ifdef PACKET_TX_CRC8_EN
    localparam int          CRCB   = 8;
`else
    localparam int          CRCB   = 0;
`endif
    localparam int          DATA_SYMS  = PREB + 16 + NBITS + CRCB;
    localparam int          FRAME_SYMS = DATA_SYMS + GAPB;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NBITS-1:0] packet_in = '0;
    logic             packet_valid = 1'b0;
    logic             bit_tick = 1'b0;
    logic             tx_bit, tx_valid, tx_busy, hold_full, dropped;

    packet_tx_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .packet_in    (packet_in),
        .packet_valid (packet_valid),
        .bit_tick     (bit_tick),
        .tx_bit       (tx_bit),
        .tx_valid     (tx_valid),
        .tx_busy      (tx_busy),
        .hold_full    (hold_full),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check96(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CRC-8, poly 0x07, init 0, over payload bits in transmit order.
    function automatic logic [7:0] crc8_model(input logic [NBITS-1:0] pkt);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int b = 0; b < PB; b++) begin
            for (int i = 7; i >= 0; i--) begin
                fb = c[7] ^ pkt[b*8+i];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // Symbol k of the frame carrying pkt: {valid, bit}.
    function automatic logic [1:0] sym_at(input logic [NBITS-1:0] pkt, input int k);
        int         j;
        logic [7:0] c;
        if (k < PREB) return {1'b1, (k % 2 == 0)};
        if (k < PREB + 16) return {1'b1, SW[15-(k-PREB)]};
        if (k < PREB + 16 + NBITS) begin
            j = k - PREB - 16;
            return {1'b1, pkt[(j/8)*8 + 7 - (j%8)]};
        end
        if (k < DATA_SYMS) begin
            c = crc8_model(pkt);
            return {1'b1, c[7-(k-PREB-16-NBITS)]};
        end
        return 2'b00;
    endfunction

    // Reference model: a queue of pending symbols, one popped per tick.
    logic [1:0]       msym[$];
    logic [NBITS-1:0] m_hold = '0;
    logic             m_hold_full = 1'b0;
    logic             m_busy = 1'b0;
    logic             m_valid = 1'b0;
    logic             m_bit = 1'b0;
    logic             m_drop = 1'b0;
    logic [1:0]       m_s;
    logic             m_exit;

    function automatic void load_frame(input logic [NBITS-1:0] pkt);
        msym.delete();
        for (int k = 0; k < FRAME_SYMS; k++) msym.push_back(sym_at(pkt, k));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            msym.delete();
            m_hold_full = 1'b0;
            m_busy = 1'b0;
            m_valid = 1'b0;
            m_bit = 1'b0;
            m_drop = 1'b0;
        end else begin
            m_drop = 1'b0;
            if (!m_busy) begin
                if (packet_valid) begin
                    load_frame(packet_in);
                    m_busy = 1'b1;
                end
            end else begin
                m_exit = 1'b0;
                if (bit_tick && msym.size() > 0) begin
                    m_s = msym.pop_front();
                    m_valid = m_s[1];
                    m_bit = m_s[0];
                    if (msym.size() == 0) m_exit = 1'b1;
                end
                if (m_exit) begin
                    if (m_hold_full) begin
                        load_frame(m_hold);
                        if (packet_valid) m_hold = packet_in;
                        else m_hold_full = 1'b0;
                    end else if (packet_valid) begin
                        load_frame(packet_in);
                    end else begin
                        m_busy = 1'b0;
                    end
                end else if (packet_valid) begin
                    if (!m_hold_full) begin
                        m_hold = packet_in;
                        m_hold_full = 1'b1;
                    end else begin
                        m_drop = 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check1("tx_valid", tx_valid, m_valid);
            check1("tx_bit", tx_bit, m_bit);
            check1("tx_busy", tx_busy, m_busy);
            check1("hold_full", hold_full, m_hold_full);
            check1("dropped", dropped, m_drop);
        end
    end

    // Tick generator: 0 = every cycle, 1 = every 4th cycle, 2 = random.
    int tick_mode = 0;
    int tcnt = 0;
    always @(negedge clk) begin
        tcnt++;
        case (tick_mode)
            0:       bit_tick = 1'b1;
            1:       bit_tick = (tcnt % 4 == 0);
            default: bit_tick = ($urandom_range(0, 2) == 0);
        endcase
    end

    task automatic send(input logic [NBITS-1:0] pkt);
        packet_in = pkt;
        packet_valid = 1'b1;
        @(negedge clk);
        packet_valid = 1'b0;
    endtask

    logic [95:0]      cap;
    logic [NBITS-1:0] pk;
    int               cnt, drops, idle_cnt;

    initial begin
        // Model self-pins from hand-derived frame contents.
        pk = 64'h0000_0000_0000_00A5;
        checkn("model_pre0", int'(sym_at(pk, 0)), 3);
        checkn("model_pre1", int'(sym_at(pk, 1)), 2);
        checkn("model_sync2", int'(sym_at(pk, 18)), 2);
        checkn("model_sync3", int'(sym_at(pk, 19)), 3);
        checkn("model_pay0", int'(sym_at(pk, 32)), 3);
        checkn("model_pay1", int'(sym_at(pk, 33)), 2);
        checkn("model_gap", int'(sym_at(pk, DATA_SYMS)), 0);
`ifdef PACKET_TX_CRC8_EN
        checkn("model_crc", int'(crc8_model(64'h0807_0605_0403_0201)), 8'h3E);
`endif

        // Reset state.
        #2 reset = 1'b1;
        #2;
        check1("rst_tx_bit", tx_bit, 1'b0);
        check1("rst_tx_valid", tx_valid, 1'b0);
        check1("rst_tx_busy", tx_busy, 1'b0);
        check1("rst_hold_full", hold_full, 1'b0);
        check1("rst_dropped", dropped, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Scenario 1: byte0 = A5, tick always high.
        tick_mode = 0;
        @(negedge clk);
        send(64'h0000_0000_0000_00A5);
        check1("t1_lat_cycle1", tx_valid, 1'b0);
        @(negedge clk);
        check1("t1_lat_cycle2", tx_valid, 1'b1);
        for (int i = 0; i < 96; i++) begin
            cap[95-i] = tx_bit;
            @(negedge clk);
        end
        check96("t1_bits", cap, {16'hAAAA, 16'hD391, 8'hA5, 56'h0});
        repeat (6 + CRCB) @(negedge clk);
        check1("t1_busy_in_gap", tx_busy, 1'b1);
        @(negedge clk);
        check1("t1_busy_end", tx_busy, 1'b0);
        check1("t1_valid_end", tx_valid, 1'b0);

        // Scenario 2: tick every 4 cycles.
        repeat (5) @(negedge clk);
        tick_mode = 1;
        send({$urandom, $urandom});
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            if (tx_valid) cnt++;
            @(negedge clk);
        end
        checkn("t2_valid_span", cnt, (96 + CRCB) * 4);

        // Scenarios 3/4: second packet held, third dropped, back-to-back.
        tick_mode = 0;
        drops = 0;
        idle_cnt = 0;
        for (int k = 0; k < 260; k++) begin
            if (k == 12) check1("t3_hold_full", hold_full, 1'b1);
            if (dropped) drops++;
            if (k > 0 && k < 200 && !tx_busy) idle_cnt++;
            packet_valid = (k == 0 || k == 10 || k == 20);
            packet_in = {$urandom, $urandom};
            @(negedge clk);
        end
        packet_valid = 1'b0;
        checkn("t4_drop_count", drops, 1);
        checkn("t3_no_idle_between", idle_cnt, 0);

        // Scenario 5: reset during the payload.
        send({$urandom, $urandom});
        repeat (50) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check1("t5_rst_tx_bit", tx_bit, 1'b0);
        check1("t5_rst_tx_valid", tx_valid, 1'b0);
        check1("t5_rst_tx_busy", tx_busy, 1'b0);
        check1("t5_rst_hold_full", hold_full, 1'b0);
        check1("t5_rst_dropped", dropped, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        check1("t5_restart_valid", tx_valid, 1'b1);
        check1("t5_restart_bit", tx_bit, 1'b1);
        repeat (150) @(negedge clk);

        // Randomized soak: sparse ticks, then dense traffic with drops.
        tick_mode = 2;
        for (int i = 0; i < 6000; i++) begin
            packet_valid = ($urandom_range(0, 119) == 0);
            packet_in = {$urandom, $urandom};
            @(negedge clk);
        end
        tick_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            packet_valid = ($urandom_range(0, 39) == 0);
            packet_in = {$urandom, $urandom};
            @(negedge clk);
        end
        packet_valid = 1'b0;
        repeat (300) @(negedge clk);
        check1("final_idle", tx_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
